// File: rtl/eq_gain_dispatcher.sv
// Per-band dB gain store with clamped up/down/flat commands; streams changed gains to the biquad bank.
// Optional RR_SCHED_EN: round-robin band selection instead of fixed lowest-index priority.
`timescale 1ns/1ps
module eq_gain_dispatcher #(
  parameter int N_BANDS    = 8,
  parameter int GAIN_MIN   = -12,
  parameter int GAIN_MAX   = 12,
  parameter int SETTLE_CYC = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [$clog2(N_BANDS)-1:0] i_band_sel,
  input  logic                       i_up,
  input  logic                       i_down,
  input  logic                       i_flat,
  output logic [N_BANDS-1:0]         o_set,
  output logic [15:0]                o_gain,
  output logic                       o_busy,
  output logic [15:0]                o_cur_gain
);

  localparam int SEL_W = $clog2(N_BANDS);
  localparam int CNT_W = $clog2(SETTLE_CYC) + 1;
  localparam logic signed [15:0] G_MIN = 16'(GAIN_MIN);
  localparam logic signed [15:0] G_MAX = 16'(GAIN_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_SETTLE} state_t;

  state_t             state, state_nxt;
  logic signed [15:0] gain     [N_BANDS];
  logic signed [15:0] gain_nxt [N_BANDS];
  logic [N_BANDS-1:0] dirty, dirty_nxt, touched;
  logic [SEL_W-1:0]   band, band_nxt, pick, idx;
  logic               pick_vld;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [N_BANDS-1:0] set_nxt;
  logic [15:0]        gain_out_nxt;
  logic               sel_ok;
`ifdef RR_SCHED_EN
  logic [SEL_W-1:0]   last_sent, last_nxt;
`endif

  assign sel_ok = (int'(i_band_sel) < N_BANDS);

  // touched marks every band whose dirty bit a command sets this cycle
  always_comb begin
    touched = '0;
    for (int k = 0; k < N_BANDS; k++) gain_nxt[k] = gain[k];
    if (i_flat) begin
      for (int k = 0; k < N_BANDS; k++) gain_nxt[k] = '0;
      touched = '1;
    end else if (sel_ok && (i_up ^ i_down)) begin
      if (i_up && (gain[i_band_sel] < G_MAX)) begin
        gain_nxt[i_band_sel] = gain[i_band_sel] + 16'sd1;
        touched[i_band_sel]  = 1'b1;
      end else if (i_down && (gain[i_band_sel] > G_MIN)) begin
        gain_nxt[i_band_sel] = gain[i_band_sel] - 16'sd1;
        touched[i_band_sel]  = 1'b1;
      end
    end
  end

  // Scan from the highest search offset down so the lowest offset wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = N_BANDS - 1; i >= 0; i--) begin
`ifdef RR_SCHED_EN
      idx = SEL_W'((int'(last_sent) + 1 + i) % N_BANDS);
`else
      idx = SEL_W'(i);
`endif
      if (dirty[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    band_nxt     = band;
    cnt_nxt      = cnt;
    set_nxt      = '0;
    gain_out_nxt = o_gain;
    dirty_nxt    = dirty | touched;
`ifdef RR_SCHED_EN
    last_nxt     = last_sent;
`endif
    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          state_nxt     = S_SEND;
          band_nxt      = pick;
          set_nxt[pick] = 1'b1;
          // Snapshot the value the gain register holds during the SEND cycle.
          gain_out_nxt  = gain_nxt[pick];
        end
      end
      S_SEND: begin
        dirty_nxt[band] = touched[band];
        state_nxt       = S_SETTLE;
        cnt_nxt         = '0;
`ifdef RR_SCHED_EN
        last_nxt        = band;
`endif
      end
      S_SETTLE: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= S_IDLE;
      band   <= '0;
      cnt    <= '0;
      o_set  <= '0;
      o_gain <= '0;
      dirty  <= '1;
      for (int k = 0; k < N_BANDS; k++) gain[k] <= '0;
`ifdef RR_SCHED_EN
      last_sent <= SEL_W'(N_BANDS - 1);
`endif
    end else begin
      state  <= state_nxt;
      band   <= band_nxt;
      cnt    <= cnt_nxt;
      o_set  <= set_nxt;
      o_gain <= gain_out_nxt;
      dirty  <= dirty_nxt;
      for (int k = 0; k < N_BANDS; k++) gain[k] <= gain_nxt[k];
`ifdef RR_SCHED_EN
      last_sent <= last_nxt;
`endif
    end
  end

  assign o_busy     = (state != S_IDLE) || (|dirty);
  assign o_cur_gain = sel_ok ? gain[i_band_sel] : '0;

endmodule

// File: tb/tb_eq_gain_dispatcher.sv
// Bench for eq_gain_dispatcher: directed scenarios plus randomized commands against a clamped-gain model.
`timescale 1ns/1ps
module tb_eq_gain_dispatcher;

  localparam int NB   = 8;
  localparam int SC   = 4;
  localparam int GMIN = -12;
  localparam int GMAX = 12;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [2:0]  i_band_sel;
  logic        i_up, i_down, i_flat;
  logic [7:0]  o_set;
  logic [15:0] o_gain, o_cur_gain;
  logic        o_busy;

  eq_gain_dispatcher dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_band_sel(i_band_sel),
    .i_up(i_up), .i_down(i_down), .i_flat(i_flat),
    .o_set(o_set), .o_gain(o_gain), .o_busy(o_busy), .o_cur_gain(o_cur_gain)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [15:0] mg [NB];
  logic [15:0] sent_val [NB];
  logic [31:0] log_q[$];
  logic [31:0] exp_q[$];
  int          log_cyc[$];
  int          since_pulse = 100;
  int          last_band = -1;
  logic [15:0] held = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Model: each band's gain saturates at the limits; flat zeroes everything.
  task automatic model_cmd(input int sel, input logic up, input logic dn, input logic fl);
    int g;
    if (fl) begin
      for (int k = 0; k < NB; k++) mg[k] = '0;
    end else if (up != dn) begin
      g = int'($signed(mg[sel])) + (up ? 1 : -1);
      if (g > GMAX) g = GMAX;
      if (g < GMIN) g = GMIN;
      mg[sel] = 16'(g);
    end
  endtask

  // Every pulse: one-hot, spaced, carries the model's current gain, then held.
  always @(posedge i_clk) begin
    #1;
    if (!i_rst_n) begin
      since_pulse = 100;
    end else if (o_set != '0) begin
      int k;
      k = 0;
      for (int b = 0; b < NB; b++) if (o_set[b]) k = b;
      check("set_onehot", 32'($onehot(o_set)), 32'd1);
      check("pulse_spacing", 32'(since_pulse >= SC + 1), 32'd1);
      check("pulse_gain", {16'd0, o_gain}, {16'd0, mg[k]});
      log_q.push_back({16'(k), o_gain});
      log_cyc.push_back(cyc);
      sent_val[k] = o_gain;
      held = o_gain;
      last_band = k;
      since_pulse = 0;
    end else begin
      if (since_pulse < 100) since_pulse++;
      if (since_pulse <= SC) check("gain_hold", {16'd0, o_gain}, {16'd0, held});
    end
  end

  // driver tasks
  task automatic pulse_cmd(input int sel, input logic up, input logic dn, input logic fl);
    @(negedge i_clk);
    i_band_sel = 3'(sel); i_up = up; i_down = dn; i_flat = fl;
    @(posedge i_clk);
    model_cmd(sel, up, dn, fl);
    #1;
    i_up = 1'b0; i_down = 1'b0; i_flat = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge i_clk);
    #2;
  endtask

  task automatic wait_idle(output int at_cyc);
    int t;
    t = 0;
    do begin
      @(posedge i_clk); #2; t++;
    end while (o_busy && t < 400);
    check("idle_reached", 32'(o_busy), 32'd0);
    at_cyc = cyc;
  endtask

  task automatic wait_pulse();
    int t;
    t = 0;
    do begin
      @(posedge i_clk); #2; t++;
    end while (o_set == '0 && t < 100);
    check("pulse_seen", 32'(o_set != '0), 32'd1);
  endtask

  task automatic exp_push(input int band, input int g);
    exp_q.push_back({16'(band), 16'(g)});
  endtask

  // scoreboard: logged transfers against the expected queue
  task automatic check_log(input string tag);
    int n;
    check({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check(tag, log_q[i], exp_q[i]);
    exp_q.delete(); log_q.delete(); log_cyc.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_c, start;
    i_band_sel = '0; i_up = 1'b0; i_down = 1'b0; i_flat = 1'b0;
    for (int k = 0; k < NB; k++) begin mg[k] = '0; sent_val[k] = 16'hdead; end

    // reset values
    repeat (3) @(posedge i_clk);
    #2;
    check("rst_set", 32'(o_set), 32'd0);
    check("rst_gain", 32'(o_gain), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd1);
    check("rst_cur", 32'(o_cur_gain), 32'd0);

    // post-reset broadcast 0..7, 6 cycles apart, busy drops 5 after the last
    @(negedge i_clk); i_rst_n = 1'b1;
    wait_idle(idle_c);
    for (int i = 1; i < log_cyc.size(); i++)
      check("bcast_spacing", 32'(log_cyc[i] - log_cyc[i-1]), 32'd6);
    if (log_cyc.size() > 0)
      check("bcast_busy_fall", 32'(idle_c - log_cyc[log_cyc.size()-1]), 32'd5);
    for (int b = 0; b < NB; b++) exp_push(b, 0);
    check_log("bcast");

    // three ups on band 3
    for (int r = 0; r < 3; r++) begin
      pulse_cmd(3, 1'b1, 1'b0, 1'b0); cycles(9); exp_push(3, r + 1);
    end
    wait_idle(idle_c);
    check_log("up3");
    check("cur_gain3", 32'(o_cur_gain), 32'd3);

    // band 0 clamps at +12
    for (int r = 0; r < 12; r++) begin
      pulse_cmd(0, 1'b1, 1'b0, 1'b0); cycles(9); exp_push(0, r + 1);
    end
    wait_idle(idle_c);
    check_log("clamp_up");
    pulse_cmd(0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      check("clamp_busy", 32'(o_busy), 32'd0);
    end
    check("clamp_cur", 32'(o_cur_gain), 32'd12);
    check_log("clamp_no_send");

    // up and down together on band 2
    pulse_cmd(2, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      check("updown_busy", 32'(o_busy), 32'd0);
    end
    check("updown_cur", 32'(o_cur_gain), 32'd0);
    check_log("updown_no_send");

    // changes during band 2's settle
    pulse_cmd(2, 1'b1, 1'b0, 1'b0);
    wait_pulse();
    @(posedge i_clk);
    pulse_cmd(5, 1'b1, 1'b0, 1'b0);
    pulse_cmd(2, 1'b1, 1'b0, 1'b0);
    wait_idle(idle_c);
    exp_push(2, 1);
`ifdef RR_SCHED_EN
    exp_push(5, 1); exp_push(2, 2);
`else
    exp_push(2, 2); exp_push(5, 1);
`endif
    check_log("resend");

    // bands 1 and 6 dirty together right after band 4 was sent
    pulse_cmd(4, 1'b1, 1'b0, 1'b0);
    wait_pulse();
    @(posedge i_clk);
    pulse_cmd(1, 1'b1, 1'b0, 1'b0);
    pulse_cmd(6, 1'b1, 1'b0, 1'b0);
    wait_idle(idle_c);
    exp_push(4, 1);
`ifdef RR_SCHED_EN
    exp_push(6, 1); exp_push(1, 1);
`else
    exp_push(1, 1); exp_push(6, 1);
`endif
    check_log("sched_order");

    // flat with several bands nonzero
`ifdef RR_SCHED_EN
    start = (last_band + 1) % NB;
`else
    start = 0;
`endif
    pulse_cmd(0, 1'b0, 1'b0, 1'b1);
    wait_idle(idle_c);
    for (int i = 0; i < NB; i++) exp_push((start + i) % NB, 0);
    check_log("flat");

    pulse_cmd(3, 1'b1, 1'b0, 1'b0);
    pulse_cmd(7, 1'b0, 1'b1, 1'b0);
    wait_idle(idle_c);
    exp_push(3, 1); exp_push(7, -1);
    check_log("pre_flat2");

    // reset in the middle of the flat broadcast
    pulse_cmd(0, 1'b0, 1'b0, 1'b1);
    wait_pulse(); wait_pulse(); wait_pulse();
    @(negedge i_clk); i_rst_n = 1'b0;
    @(posedge i_clk);
    for (int k = 0; k < NB; k++) mg[k] = '0;
    #2;
    check("abort_set", 32'(o_set), 32'd0);
    check("abort_gain", 32'(o_gain), 32'd0);
    check("abort_busy", 32'(o_busy), 32'd1);
    repeat (2) @(negedge i_clk);
    log_q.delete(); log_cyc.delete();
    i_rst_n = 1'b1;
    wait_idle(idle_c);
    for (int b = 0; b < NB; b++) exp_push(b, 0);
    check_log("rst_bcast");

    // randomized commands: up-biased then down-biased, one flat in between
    for (int ph = 0; ph < 2; ph++) begin
      for (int n = 0; n < 120; n++) begin
        int r, sel;
        sel = $urandom_range(0, 3);
        r = $urandom_range(0, 99);
        if (ph == 1 && n == 60) pulse_cmd(sel, 1'b0, 1'b0, 1'b1);
        else if (r < 70) pulse_cmd(sel, (ph == 0), (ph == 1), 1'b0);
        else if (r < 95) pulse_cmd(sel, (ph == 1), (ph == 0), 1'b0);
        else pulse_cmd(sel, 1'b1, 1'b1, 1'b0);
        repeat ($urandom_range(0, 4)) @(posedge i_clk);
      end
    end
    wait_idle(idle_c);
    for (int k = 0; k < NB; k++) begin
      check("rand_final_sent", {16'd0, sent_val[k]}, {16'd0, mg[k]});
      @(negedge i_clk); i_band_sel = 3'(k);
      #1;
      check("rand_cur_gain", {16'd0, o_cur_gain}, {16'd0, mg[k]});
    end
    log_q.delete(); log_cyc.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
